// File: rtl/pipeline_ctrl.sv
// Central pipeline-control responder for the 5-stage core: arbitrates load-use
// stalls, EX redirects and multi-cycle data-memory waits, and keeps perf counters.
module pipeline_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbg_state      // 0 = RUN, 1 = MEM_WAIT, 2 = ERR
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
  logic ex_mem_en_c, mem_wb_bubble_c;
  logic freeze, apply_run, redirect_taken;

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    timeout_d      = timeout_q;
    freeze         = 1'b0;
    apply_run      = 1'b0;
    redirect_taken = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          apply_run = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ack) begin
          freeze = 1'b1;
          if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
          if (MEM_TIMEOUT != 0 && wait_d >= WAIT_LIMIT) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end else begin
          // Ack cycle: stalled ID/EX inputs were frozen, so honour them now.
          apply_run = 1'b1;
          state_d   = ST_RUN;
          wait_d    = '0;
        end
      end
      ST_ERR: begin
        freeze    = 1'b1;
        timeout_d = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = ST_ERR;
      end
    endcase

    pc_en_c         = 1'b1;
    if_id_en_c      = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_en_c      = 1'b1;
    id_ex_flush_c   = 1'b0;
    ex_mem_en_c     = 1'b1;
    mem_wb_bubble_c = 1'b0;

    if (freeze) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      id_ex_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end else if (apply_run && ex_redirect) begin
      // Redirect wins over load-use: the instruction in ID is wrong-path.
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      redirect_taken = 1'b1;
    end else if (apply_run && load_use_stall) begin
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      id_ex_flush_c = 1'b1;
    end

    if (!rst_n) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      if_id_flush_c   = 1'b0;
      id_ex_en_c      = 1'b0;
      id_ex_flush_c   = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end

    stall_d = stall_q;
    if (!pc_en_c && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
    flush_d = flush_q;
    if (redirect_taken && flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign pc_en         = pc_en_c;
  assign if_id_en      = if_id_en_c;
  assign if_id_flush   = if_id_flush_c;
  assign id_ex_en      = id_ex_en_c;
  assign id_ex_flush   = id_ex_flush_c;
  assign ex_mem_en     = ex_mem_en_c;
  assign mem_wb_bubble = mem_wb_bubble_c;
  assign mem_timeout   = timeout_q;
  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the control rules.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 4;
  localparam int TO      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  logic clk = 1'b0;
  logic rst_n, load_use_stall, ex_redirect, dmem_req, dmem_ack;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: plain mode flags and integer counters.
  bit m_waiting = 0;
  bit m_error   = 0;
  int m_waits   = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  logic [6:0] exp_q[$];

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};
  endfunction

  function automatic int state_code();
    return m_error ? 2 : (m_waiting ? 1 : 0);
  endfunction

  function automatic logic [6:0] model_ctrl();
    if (!rst_n) return C_FREEZE;
    if (m_error) return C_FREEZE;
    if (!dmem_ack && (m_waiting || dmem_req)) return C_FREEZE;
    if (ex_redirect) return C_REDIR;
    if (load_use_stall) return C_LDUSE;
    return C_NORMAL;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_error = 0; m_waits = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_clock(input logic [6:0] c);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!c[6]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (c == C_REDIR) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_error) begin
        m_error = 1;
      end else if (!m_waiting) begin
        if (dmem_req && !dmem_ack) begin m_waiting = 1; m_waits = 1; end
      end else if (dmem_ack) begin
        m_waiting = 0;
      end else begin
        m_waits++;
        if (m_waits >= TO) begin m_error = 1; m_waiting = 0; end
      end
    end
  endtask

  task automatic check_regs();
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    chk("state", 32'(dbg_state), 32'(state_code()));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_error));
  endtask

  // One clock cycle: drive at negedge, check controls, then check state after posedge.
  task automatic cycle(input logic r, input logic q, input logic a, input logic l, input logic x);
    logic [6:0] e;
    @(negedge clk);
    rst_n = r; dmem_req = q; dmem_ack = a; load_use_stall = l; ex_redirect = x;
    #2;
    exp_q.push_back(model_ctrl());
    e = exp_q.pop_front();
    chk("ctrl", 32'(ctrl_now()), 32'(e));
    model_clock(e);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0; load_use_stall = 1'b0; ex_redirect = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
    chk("reset_stall", 32'(stall_cycles), 32'd0);

    // Single load-use cycle
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Redirect beats load-use
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("redir_flush_cnt", 32'(flush_count), 32'd1);
    chk("redir_stall_cnt", 32'(stall_cycles), 32'd0);

    // Access acked after three frozen cycles
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b1;
    #2;
    chk("ack_ctrl", 32'(ctrl_now()), 32'(C_NORMAL));
    model_clock(C_NORMAL);
    @(posedge clk); #1;
    check_regs();
    chk("wait3_stall", 32'(stall_cycles), 32'd3);
    chk("wait3_state", 32'(dbg_state), 32'd0);

    // Same-cycle ack: no freeze
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fast_ack_stall", 32'(stall_cycles), 32'd0);

    // Timeout: ack never arrives
    do_reset();
    for (int i = 0; i < TO; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("timeout_flag", 32'(mem_timeout), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("err_freeze", 32'(ctrl_now()), 32'(C_FREEZE));
    chk("err_state", 32'(dbg_state), 32'd2);
    do_reset();
    chk("err_cleared", 32'(mem_timeout), 32'd0);

    // Counter saturation, then async reset in the middle of a wait
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stall_sat", 32'(stall_cycles), 32'(CNT_MAX));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
    chk("async_rst_stall", 32'(stall_cycles), 32'd0);
    chk("async_rst_state", 32'(dbg_state), 32'd0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 14) != 0), logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
